sonar_ping_ctrl: RTL and testbench
==================================

Name: sonar_ping_ctrl

Overview:
Sequences one ultrasonic ranging cycle on a sonar I/O pin pair. It emits a fixed-width trigger pulse, waits for the echo rising edge, and measures the echo high time in whole microseconds. It then enforces a hold-off before the next ping. It sits between the CPU's memory-mapped I/O and the physical trig/echo pins, and replaces software bit-banging of io_pin plus the µs counter.

Parameters:
CLK_PER_US, 50, clock cycles per microsecond (50 MHz system clock)
TRIG_US, 10, trigger pulse width in µs
TIMEOUT_US, 30000, maximum µs allowed in each of WAIT_RISE and MEASURE
GAP_US, 60000, hold-off in µs after each ping before the controller returns to IDLE
W, 16, width of echo_us result; must hold TIMEOUT_US

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low; reset=0 clears all state
start  in  1  ping request, sampled only in IDLE
echo  in  1  raw echo pin, asynchronous to clk
trig  out  1  trigger pin drive
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a result is written
timeout  out  1  sticky flag for the last ping; updated together with done
echo_us  out  W  last measured echo width in µs; held until the next done

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Reset values: state=IDLE, trig=0, busy=0, done=0, timeout=0, echo_us=0. Prescaler, µs counter and synchronizer flops are all 0.
- Echo input passes through a 2-flop synchronizer giving echo_s. An edge register gives rise = echo_s & ~echo_q and fall = ~echo_s & echo_q.
- Prescaler counts 0..CLK_PER_US-1. us_tick = (prescaler==CLK_PER_US-1).
- µs counter increments on us_tick. Both the prescaler and the µs counter clear on every state transition, so every interval starts exactly aligned.
- IDLE:
  - start=1 -> TRIG.
  - start in any other state is ignored, not queued.
- TRIG:
  - trig=1 for exactly TRIG_US*CLK_PER_US cycles.
  - -> WAIT_RISE on the us_tick where count reaches TRIG_US.
- WAIT_RISE:
  - rise -> MEASURE.
  - count==TIMEOUT_US -> result with timeout=1, echo_us=0, then HOLDOFF.
  - Echo already high on entry does not count; a fresh rising edge is required.
- MEASURE:
  - fall -> echo_us=count of completed µs (fractional µs truncated), timeout=0, done=1, then HOLDOFF.
  - count==TIMEOUT_US -> echo_us=TIMEOUT_US, timeout=1, done=1, then HOLDOFF.
  - If fall and timeout occur in the same cycle, fall wins (timeout=0, echo_us=TIMEOUT_US).
- HOLDOFF:
  - trig=0; wait GAP_US µs, then -> IDLE.
- done is registered: it asserts in the cycle the state enters HOLDOFF and deasserts next cycle. echo_us and timeout change only in that same cycle.
- Latency:
  - start to trig rising: 1 cycle.
  - echo pin edge to internal detection: 3 cycles.
- reset=0 mid-ping: trig drops immediately (asynchronous). All outputs go to their reset values and the pending result is discarded.

Optional Feature:
SONAR_AUTO_TRIG_EN
- Defined: extra input port auto (1 bit). When auto=1 in HOLDOFF at GAP expiry, go directly to TRIG for free-running pings. busy stays high throughout. auto=0 behaves as the base design.
- Undefined: no auto port; HOLDOFF always -> IDLE.

Decomposition:
- Shared package sonar_pkg:
  - state encoding localparams: IDLE=0, TRIG=1, WAIT_RISE=2, MEASURE=3, HOLDOFF=4 (3-bit).
  - Default timing constants CLK_PER_US, TRIG_US, TIMEOUT_US, GAP_US.
- One sub-module: sonar_us_timer. It holds the prescaler plus the µs counter, with inputs clr and reset, and outputs us_tick and count[W-1:0].
- Synchronizer and FSM live in the top module.

Test Plan:
All scenarios use CLK_PER_US=5, TRIG_US=10, TIMEOUT_US=100, GAP_US=20, W=16.
1. Reset, pulse start once -> trig high exactly 50 cycles; busy high from the cycle after start.
2. Echo high 37 µs + 3 cycles after trig falls -> done pulse once, echo_us=37, timeout=0. Then 20 µs hold-off, then busy=0.
3. Echo never rises -> after 100 µs in WAIT_RISE: done=1, timeout=1, echo_us=0.
4. Echo rises and stays high -> done with timeout=1, echo_us=100. Next start succeeds and the old value is held until the new done.
5. Echo held high before start; start pulsed during HOLDOFF -> HOLDOFF start ignored; stale high does not enter MEASURE; result is a timeout.
6. reset=0 midway through MEASURE -> trig=0, busy=0, echo_us=0, done never pulses. With SONAR_AUTO_TRIG_EN and auto=1 -> trig re-asserts exactly 20 µs after done.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared constants and state encoding for the sonar ping controller.
package sonar_pkg;

  localparam int unsigned DEF_CLK_PER_US = 50;
  localparam int unsigned DEF_TRIG_US    = 10;
  localparam int unsigned DEF_TIMEOUT_US = 30000;
  localparam int unsigned DEF_GAP_US     = 60000;
  localparam int unsigned DEF_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_e;

endpackage

// File: rtl/sonar_us_timer.sv
// Microsecond timebase: prescaler over CLK_PER_US cycles plus a us counter.
// clr restarts both so every interval begins on a whole-us boundary.
module sonar_us_timer #(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned W          = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  output logic         us_tick,
  output logic [W-1:0] count
);

  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [PW-1:0] presc_d, presc_q;
  logic [W-1:0]  count_d, count_q;
  logic          tick_d, tick_q;

  // Next prescaler / counter values; tick flags the last cycle of each us
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    if (clr) begin
      presc_d = '0;
      count_d = '0;
    end else if (tick_q) begin
      presc_d = '0;
      count_d = count_q + W'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
    tick_d = (presc_d == PW'(CLK_PER_US - 1));
  end

  // Timer state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      count_q <= '0;
      tick_q  <= 1'(CLK_PER_US == 1);
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign us_tick = tick_q;
  assign count   = count_q;

endmodule

// File: rtl/sonar_ping_ctrl.sv
// Sonar ping controller: trigger pulse, echo rise wait, echo width in us,
// then a hold-off before the next ping.
// Build option SONAR_AUTO_TRIG_EN adds an 'auto' input that re-triggers
// straight from HOLDOFF for free-running pings.
module sonar_ping_ctrl
  import sonar_pkg::*;
#(
  parameter int unsigned CLK_PER_US = DEF_CLK_PER_US,
  parameter int unsigned TRIG_US    = DEF_TRIG_US,
  parameter int unsigned TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int unsigned GAP_US     = DEF_GAP_US,
  parameter int unsigned W          = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         echo,
`ifdef SONAR_AUTO_TRIG_EN
  input  logic         auto,
`endif
  output logic         trig,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [W-1:0] echo_us
);

  state_e         state_q, state_d;
  logic           echo_meta_q, echo_s_q, echo_q;
  logic           rise, fall;
  logic           clr_c;
  logic           us_tick;
  logic [W-1:0]   count;
  logic           trig_d, trig_q;
  logic           busy_d, busy_q;
  logic           done_d, done_q;
  logic           timeout_d, timeout_q;
  logic [W-1:0]   echo_us_d, echo_us_q;

  // Two-flop synchronizer plus edge register on the asynchronous echo pin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_q      <= 1'b0;
    end else begin
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      echo_q      <= echo_s_q;
    end
  end

  assign rise = echo_s_q & ~echo_q;
  assign fall = ~echo_s_q & echo_q;

  sonar_us_timer #(
    .CLK_PER_US (CLK_PER_US),
    .W          (W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr_c),
    .us_tick (us_tick),
    .count   (count)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    echo_us_d = echo_us_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_TRIG;
      end
      ST_TRIG: begin
        if (us_tick && (count == W'(TRIG_US - 1))) state_d = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end else if (count == W'(TIMEOUT_US)) begin
          state_d   = ST_HOLDOFF;
          timeout_d = 1'b1;
          echo_us_d = '0;
        end
      end
      ST_MEASURE: begin
        // A fall on the timeout cycle still counts as a valid echo
        if (fall || (count == W'(TIMEOUT_US))) begin
          state_d   = ST_HOLDOFF;
          timeout_d = ~fall;
          echo_us_d = count;
        end
      end
      ST_HOLDOFF: begin
        if (us_tick && (count == W'(GAP_US - 1))) begin
`ifdef SONAR_AUTO_TRIG_EN
          state_d = auto ? ST_TRIG : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    clr_c  = (state_d != state_q);
    trig_d = (state_d == ST_TRIG);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_HOLDOFF) && (state_q != ST_HOLDOFF);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      echo_us_q <= '0;
    end else begin
      state_q   <= state_d;
      trig_q    <= trig_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      echo_us_q <= echo_us_d;
    end
  end

  assign trig    = trig_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign echo_us = echo_us_q;

endmodule

// File: tb/tb_sonar_ping_ctrl.sv
// Self-checking bench for sonar_ping_ctrl with reduced timing constants.
module tb_sonar_ping_ctrl;

  localparam int unsigned CPU     = 5;
  localparam int unsigned TRIG_US = 10;
  localparam int unsigned TO_US   = 100;
  localparam int unsigned GAP_US  = 20;
  localparam int unsigned W       = 16;
  localparam int TRIG_CYC = int'(CPU * TRIG_US);
  localparam int GAP_CYC  = int'(CPU * GAP_US);
  localparam int TO_CYC   = int'(CPU * TO_US);

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         echo  = 1'b0;
`ifdef SONAR_AUTO_TRIG_EN
  logic         auto_en = 1'b0;
`endif
  logic         trig, busy, done, timeout;
  logic [W-1:0] echo_us;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned last_us  = 0;
  bit          last_to  = 1'b0;

  always #5 clk = ~clk;

  sonar_ping_ctrl #(
    .CLK_PER_US (CPU),
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TO_US),
    .GAP_US     (GAP_US),
    .W          (W)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .start   (start),
    .echo    (echo),
`ifdef SONAR_AUTO_TRIG_EN
    .auto    (auto_en),
`endif
    .trig    (trig),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .echo_us (echo_us)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected result from echo timing, with delay counted in cycles after the
  // trigger has been seen low and width the number of cycles echo is high.
  // The synchronizer makes an edge visible two cycles after the pin moves;
  // WAIT_RISE gives up once TO_US whole us have elapsed; MEASURE starts the
  // cycle after the rise is seen, so a fall seen k cycles after the rise
  // reports floor((k-1)/CPU) completed us, capped by the timeout.
  function automatic void ref_result(input int delay, input int width,
                                     output int unsigned us, output bit to);
    int rise_at;
    int hi;
    rise_at = delay + 2;
    if (width == 0 || rise_at >= TO_CYC) begin
      us = 0;
      to = 1'b1;
    end else begin
      hi = width - 1;
      if (hi <= TO_CYC) begin
        us = int'(hi) / int'(CPU);
        to = 1'b0;
      end else begin
        us = TO_US;
        to = 1'b1;
      end
    end
  endfunction

  // One full ping: start pulse, trigger width, echo shape, result, hold-off
  task automatic run_ping(input string tag, input int delay, input int width,
                          input int unsigned exp_us, input bit exp_to, input bit poke);
    int n;
    int m;
    bit held_ok;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "/trig_latency"}, 32'(trig), 32'd1);
    check({tag, "/busy_on"}, 32'(busy), 32'd1);
    n = 0;
    while (trig && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check({tag, "/trig_width"}, 32'(n), 32'(TRIG_CYC));
    held_ok = 1'b1;
    fork
      begin
        if (width > 0) begin
          repeat (delay) @(negedge clk);
          echo = 1'b1;
          repeat (width) @(negedge clk);
          echo = 1'b0;
        end
      end
      begin
        m = 0;
        while (!done && m < 2000) begin
          if (echo_us !== W'(last_us) || timeout !== last_to) held_ok = 1'b0;
          m++;
          @(negedge clk);
        end
        check({tag, "/done_seen"}, 32'(done), 32'd1);
        check({tag, "/old_result_held"}, 32'(held_ok), 32'd1);
        check({tag, "/echo_us"}, 32'(echo_us), 32'(exp_us));
        check({tag, "/timeout"}, 32'(timeout), 32'(exp_to));
        @(negedge clk);
        check({tag, "/done_one_cycle"}, 32'(done), 32'd0);
        m = 1;
        while (busy && m < 2000) begin
          start = poke && (m == 10);
          m++;
          @(negedge clk);
        end
        start = 1'b0;
        check({tag, "/holdoff_len"}, 32'(m), 32'(GAP_CYC));
      end
    join
    last_us = exp_us;
    last_to = exp_to;
    if (poke) begin
      n = 0;
      repeat (20) begin
        @(negedge clk);
        if (busy) n++;
      end
      check({tag, "/start_in_holdoff_ignored"}, 32'(n), 32'd0);
    end
  endtask

  typedef struct {
    int          delay;
    int          width;
    int unsigned exp_us;
    bit          exp_to;
  } vec_t;

  vec_t vecs[9];

  initial begin : main
    int n;
    int d;
    int w;
    int unsigned eu;
    bit et;

    // delay, width (0 = echo never driven), expected echo_us, timeout
    vecs[0] = '{5,   188, 37,  1'b0};   // 37 us + 3 cycles
    vecs[1] = '{3,   185, 36,  1'b0};   // exactly 37 us of pin time
    vecs[2] = '{0,   1,   0,   1'b0};   // shortest pulse, immediate rise
    vecs[3] = '{10,  6,   1,   1'b0};
    vecs[4] = '{20,  501, 100, 1'b0};   // fall on timeout cycle wins
    vecs[5] = '{20,  502, 100, 1'b1};   // echo stays high past timeout
    vecs[6] = '{600, 0,   0,   1'b1};   // echo never rises
    vecs[7] = '{497, 50,  9,   1'b0};   // rise on last WAIT_RISE cycle
    vecs[8] = '{499, 50,  0,   1'b1};   // rise just after WAIT_RISE gives up

    // Reset values
    repeat (3) @(negedge clk);
    check("rst/trig", 32'(trig), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/timeout", 32'(timeout), 32'd0);
    check("rst/echo_us", 32'(echo_us), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle/busy", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++)
      run_ping($sformatf("vec%0d", i), vecs[i].delay, vecs[i].width,
               vecs[i].exp_us, vecs[i].exp_to, 1'b0);

    // Randomized pings against the reference model
    for (int i = 0; i < 15; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        d = int'($urandom_range(540, 499));
        w = int'($urandom_range(40, 1));
      end else begin
        d = int'($urandom_range(497, 0));
        w = int'($urandom_range(520, 1));
      end
      ref_result(d, w, eu, et);
      run_ping($sformatf("rnd%0d", i), d, w, eu, et, 1'b0);
    end

    // Echo already high before start, start poked during HOLDOFF
    echo = 1'b1;
    repeat (10) @(negedge clk);
    run_ping("stale", 0, 0, 0, 1'b1, 1'b1);
    echo = 1'b0;
    repeat (5) @(negedge clk);

    // Leave a nonzero result, then reset in the middle of MEASURE
    run_ping("pre_rst", 5, 188, 37, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (trig && n < 1000) begin
      n++;
      @(negedge clk);
    end
    echo = 1'b1;
    repeat (100) @(negedge clk);
    check("mid_meas/busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_meas/trig", 32'(trig), 32'd0);
    check("mid_meas/busy", 32'(busy), 32'd0);
    check("mid_meas/done", 32'(done), 32'd0);
    check("mid_meas/timeout", 32'(timeout), 32'd0);
    check("mid_meas/echo_us", 32'(echo_us), 32'd0);
    last_us = 0;
    last_to = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 700; k++) begin
      if (k == 50) echo = 1'b0;
      @(negedge clk);
      if (done || busy) n++;
    end
    check("mid_meas/no_done_after_reset", 32'(n), 32'd0);

    // Reset during TRIG drops the pin without waiting for a clock
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_trig/trig_before", 32'(trig), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_trig/trig_async", 32'(trig), 32'd0);
    check("mid_trig/busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

`ifdef SONAR_AUTO_TRIG_EN
    // Free-running: trig returns exactly GAP_US after done
    begin : auto_seq
      bit busy_ok;
      auto_en = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (trig && n < 1000) begin
        n++;
        @(negedge clk);
      end
      repeat (5) @(negedge clk);
      echo = 1'b1;
      repeat (40) @(negedge clk);
      echo = 1'b0;
      n = 0;
      while (!done && n < 2000) begin
        n++;
        @(negedge clk);
      end
      check("auto/done_seen", 32'(done), 32'd1);
      check("auto/echo_us", 32'(echo_us), 32'd7);
      n = 0;
      busy_ok = 1'b1;
      while (!trig && n < 500) begin
        if (!busy) busy_ok = 1'b0;
        n++;
        @(negedge clk);
      end
      check("auto/retrig_gap", 32'(n), 32'(GAP_CYC));
      check("auto/busy_held", 32'(busy_ok), 32'd1);
      auto_en = 1'b0;
      n = 0;
      while (busy && n < 3000) begin
        n++;
        @(negedge clk);
      end
      check("auto/returns_idle", 32'(busy), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
